// File: rtl/pc_sequencer_if.sv
// Instruction-fetch port between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic        FetchAck;
  logic        InstrValid;

  modport master (output FetchReq, output FetchAddr, output InstrValid, input FetchAck);
  modport slave  (input FetchReq, input FetchAddr, input InstrValid, output FetchAck);
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and single-outstanding fetch sequencer; a redirect that arrives
// while a fetch is in flight is parked until that fetch is acknowledged.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  input  logic                 Jump,
  input  logic [31:0]          JumpTarget,
  input  logic                 JumpReg,
  input  logic [31:0]          RegTarget,
  input  logic                 Exception,
  input  logic [31:0]          ExcPc,
  input  logic                 Eret,
  pc_sequencer_if.master       fetch,
  output logic [31:0]          Epc,
  output logic [31:0]          PC
);

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_FETCH} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_epc, r_pend_tgt;
  logic [2:0]  r_pend_prio;
  logic        r_pend;

  logic        w_redir, w_take_new, w_req, w_valid;
  logic [31:0] w_redir_tgt;
  logic [2:0]  w_redir_prio;

  // Larger prio value wins; a newer redirect replaces a parked one on ties.
  always_comb begin
    w_redir      = 1'b1;
    w_redir_tgt  = 32'h0;
    w_redir_prio = 3'd0;
    if (Exception) begin
      w_redir_tgt  = EXC_VECTOR;
      w_redir_prio = 3'd4;
    end else if (Eret) begin
      w_redir_tgt  = r_epc;
      w_redir_prio = 3'd3;
    end else if (JumpReg) begin
      w_redir_tgt  = RegTarget;
      w_redir_prio = 3'd2;
    end else if (Jump) begin
      w_redir_tgt  = JumpTarget;
      w_redir_prio = 3'd1;
    end else if (BranchTaken) begin
      w_redir_tgt  = BranchTarget;
      w_redir_prio = 3'd0;
    end else begin
      w_redir = 1'b0;
    end
    w_redir_tgt = {w_redir_tgt[31:2], 2'b00};
  end

  assign w_take_new = w_redir && (!r_pend || (w_redir_prio >= r_pend_prio));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_BOOT:  w_state_nxt = Stall ? ST_IDLE : ST_FETCH;
      ST_IDLE:  if (!Stall) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_req = 1'b1;
        if (fetch.FetchAck) begin
          w_valid     = !(r_pend || w_redir);
          w_state_nxt = Stall ? ST_IDLE : ST_FETCH;
        end
      end
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc        <= RESET_VECTOR;
      r_epc       <= 32'h0;
      r_pend      <= 1'b0;
      r_pend_prio <= 3'd0;
    end else begin
      if (Exception) r_epc <= ExcPc;
      if (r_state == ST_FETCH) begin
        if (fetch.FetchAck) begin
          r_pend <= 1'b0;
          if (w_take_new)  r_pc <= w_redir_tgt;
          else if (r_pend) r_pc <= r_pend_tgt;
          else             r_pc <= r_pc + 32'd4;
        end else if (w_take_new) begin
          r_pend      <= 1'b1;
          r_pend_prio <= w_redir_prio;
        end
      end else if (w_redir) begin
        r_pc <= w_redir_tgt;
      end
    end
  end

  // Parked target is pure data; r_pend qualifies it.
  always_ff @(posedge Clk) begin
    if (r_state == ST_FETCH && !fetch.FetchAck && w_take_new) r_pend_tgt <= w_redir_tgt;
  end

  assign fetch.FetchReq   = w_req;
  assign fetch.FetchAddr  = r_pc;
  assign fetch.InstrValid = w_valid;
  assign PC               = r_pc;
  assign Epc              = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer with a scoreboard fed by a behavioural fetch model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, br, jmp, jr, exc, eret;
  logic [31:0] bt, jt, rt, ep;
  logic [31:0] epc, pc;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .Clk(clk), .Reset(rst_n), .Stall(stall),
    .BranchTaken(br), .BranchTarget(bt),
    .Jump(jmp), .JumpTarget(jt),
    .JumpReg(jr), .RegTarget(rt),
    .Exception(exc), .ExcPc(ep), .Eret(eret),
    .fetch(bus), .Epc(epc), .PC(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] epc;
  } exp_t;

  exp_t        st_q[$];
  logic [31:0] instr_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference: where the program counter is, whether a fetch is in flight,
  // and the best redirect seen while that fetch was waiting.
  logic [31:0] m_pc, m_epc, m_park_tgt;
  bit          m_in_flight, m_parked;
  int          m_park_rank;

  function automatic void model_cycle();
    bit          have;
    int          rank;
    logic [31:0] tgt;
    exp_t        e;
    if (!rst_n) begin
      m_pc = 32'h0000_3000; m_epc = 0; m_in_flight = 0; m_parked = 0; m_park_rank = 0;
      e.req = 0; e.valid = 0; e.pc = m_pc; e.epc = m_epc;
      st_q.push_back(e);
      return;
    end
    have = 1; rank = 0; tgt = 0;
    if (exc)       begin tgt = 32'h0000_4180; rank = 4; end
    else if (eret) begin tgt = m_epc;         rank = 3; end
    else if (jr)   begin tgt = rt;            rank = 2; end
    else if (jmp)  begin tgt = jt;            rank = 1; end
    else if (br)   begin tgt = bt;            rank = 0; end
    else have = 0;
    tgt = tgt & 32'hFFFF_FFFC;
    e.req   = m_in_flight;
    e.valid = m_in_flight && bus.FetchAck && !(m_parked || have);
    e.pc    = m_pc;
    e.epc   = m_epc;
    st_q.push_back(e);
    if (e.valid) instr_q.push_back(m_pc);
    if (m_in_flight && bus.FetchAck) begin
      if (have && (!m_parked || rank >= m_park_rank)) m_pc = tgt;
      else if (m_parked)                              m_pc = m_park_tgt;
      else                                            m_pc = m_pc + 32'd4;
      m_parked    = 0;
      m_in_flight = !stall;
    end else if (m_in_flight) begin
      if (have && (!m_parked || rank >= m_park_rank)) begin
        m_parked = 1; m_park_tgt = tgt; m_park_rank = rank;
      end
    end else begin
      if (have) m_pc = tgt;
      m_in_flight = !stall;
    end
    if (exc) m_epc = ep;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t        mon_e;
  logic [31:0] mon_addr;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_e = st_q.pop_front();
      check("FetchReq",   {31'b0, bus.FetchReq},   {31'b0, mon_e.req});
      check("InstrValid", {31'b0, bus.InstrValid}, {31'b0, mon_e.valid});
      check("PC",         pc,            mon_e.pc);
      check("FetchAddr",  bus.FetchAddr, mon_e.pc);
      check("Epc",        epc,           mon_e.epc);
    end
    if (bus.InstrValid === 1'b1) begin
      if (instr_q.size() == 0) begin
        check("unexpected_instr", bus.FetchAddr, 32'hxxxx_xxxx);
      end else begin
        mon_addr = instr_q.pop_front();
        check("instr_addr", bus.FetchAddr, mon_addr);
      end
    end
  end

  // Inputs are applied just after a rising edge; the model sees the same values.
  task automatic tick();
    model_cycle();
    @(posedge clk); #1;
    br = 0; jmp = 0; jr = 0; exc = 0; eret = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 0; stall = 0; br = 0; jmp = 0; jr = 0; exc = 0; eret = 0;
    bt = 0; jt = 0; rt = 0; ep = 0; bus.FetchAck = 0;
    @(posedge clk); #1;
    ticks(2);
    // Zero-wait sequential fetches from the reset vector
    rst_n = 1; bus.FetchAck = 1;
    ticks(3);
    // Held request across wait states
    bus.FetchAck = 0; ticks(3);
    bus.FetchAck = 1; ticks(2);
    // Branch while a fetch is waiting
    bus.FetchAck = 0; br = 1; bt = 32'h0000_3100; tick();
    tick();
    bus.FetchAck = 1; ticks(2);
    // Exception and jump together while idle, then return
    stall = 1; tick();
    bus.FetchAck = 0; exc = 1; ep = 32'h0000_3020; jmp = 1; jt = 32'h0000_5000; tick();
    stall = 0; tick();
    bus.FetchAck = 1; ticks(2);
    eret = 1; tick();
    ticks(2);
    // Stall during an outstanding fetch
    bus.FetchAck = 0; stall = 1; ticks(2);
    bus.FetchAck = 1; tick();
    bus.FetchAck = 0; ticks(2);
    stall = 0; tick();
    bus.FetchAck = 1; ticks(2);
    // Unaligned register target, wrap at the top of the address space
    jr = 1; rt = 32'hFFFF_FFFF; tick();
    ticks(2);
    // Reset dropped while a fetch is outstanding
    bus.FetchAck = 0; tick();
    rst_n = 0; tick();
    rst_n = 1; ticks(3);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      bus.FetchAck = $urandom_range(0, 1);
      br   = ($urandom_range(0, 11) == 0);
      jmp  = ($urandom_range(0, 11) == 0);
      jr   = ($urandom_range(0, 11) == 0);
      exc  = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 11) == 0);
      bt = $urandom(); jt = $urandom(); ep = $urandom();
      rt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom();
      tick();
    end
    rst_n = 1; bus.FetchAck = 0;
    @(negedge clk); #1;
    check("queue_drained", st_q.size() + instr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller and fetch sequencer for the MIPS core. It owns the PC register and issues one instruction-fetch request at a time to instruction memory over a req/ack handshake. It selects the next PC among sequential, branch, jump, jump-register, exception and ERET sources, and handles redirects that arrive while a fetch is outstanding. It sits between the decode/execute redirect logic and the instruction memory port.

Parameters:
RESET_VECTOR, 32'h0000_3000, PC value after reset
EXC_VECTOR, 32'h0000_4180, exception handler entry address

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low (0 = reset)
Stall  input  1  pipeline stall; blocks issue of new fetches
BranchTaken  input  1  taken-branch redirect, single-cycle pulse
BranchTarget  input  32  branch target address
Jump  input  1  J/JAL redirect pulse
JumpTarget  input  32  jump target address
JumpReg  input  1  JR/JALR redirect pulse
RegTarget  input  32  register jump target
Exception  input  1  exception redirect pulse
ExcPc  input  32  PC of the faulting instruction
Eret  input  1  return-from-exception pulse
FetchAck  input  1  instruction memory accepted and returned the current fetch
FetchReq  output  1  fetch request
FetchAddr  output  32  fetch address; equals PC
InstrValid  output  1  fetched instruction is valid for decode this cycle
Epc  output  32  saved exception PC
PC  output  32  current PC register

Behaviour:
- Reset (asynchronous, Reset=0): PC=RESET_VECTOR, Epc=0, FetchReq=0, InstrValid=0, pending-redirect flag cleared, state=BOOT. Reset asserted mid-fetch abandons the fetch immediately, with no InstrValid.
- States:
  - BOOT: one cycle after reset release, FetchReq=0. Goes to FETCH if Stall=0, else to IDLE.
  - IDLE: FetchReq=0. Goes to FETCH when Stall=0.
  - FETCH: FetchReq=1.
- Handshake: FetchReq stays high and FetchAddr stays stable until FetchAck=1. A zero-wait ack in the same cycle gives one fetch per cycle. FetchAck outside FETCH is ignored.
- On FetchAck in FETCH:
  - InstrValid = FetchAck & ~drop, combinational. drop = pending flag set, or a redirect present in the same cycle.
  - PC loads the redirect target if a redirect is present or pending, otherwise PC+4.
  - Next state is FETCH if Stall=0, otherwise IDLE.
- Redirect priority: Exception > Eret > JumpReg > Jump > BranchTaken. Targets:
  - Exception: EXC_VECTOR
  - Eret: Epc
  - JumpReg: RegTarget
  - Jump: JumpTarget
  - BranchTaken: BranchTarget
  - All targets have bits [1:0] forced to 00.
- Redirect outside FETCH (BOOT/IDLE): PC loads the target on the next edge.
- Redirect in FETCH without FetchAck: the target is latched into a one-entry pending register and the flag is set. The outstanding fetch still completes; its instruction is dropped and the pending target is loaded on that ack.
- A later redirect while one is pending overwrites it only if it has higher or equal priority. Exception always overwrites.
- Exception: Epc <= ExcPc on the same edge. Exception and Eret together: Exception wins and Epc is updated.
- Stall does not cancel an outstanding request. Stall=1 with no outstanding fetch holds PC and FetchReq=0.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Reset release, Stall=0, FetchAck tied 1 -> FetchReq rises in the 2nd cycle. FetchAddr steps 0x3000, 0x3004, 0x3008; InstrValid=1 each cycle.
- FetchAck delayed 3 cycles at PC=0x3008 -> FetchAddr is held at 0x3008 for all waiting cycles; a single InstrValid pulse; then 0x300C.
- BranchTaken (target 0x3100) pulsed while a fetch at 0x3010 waits for ack -> on ack InstrValid=0; next FetchAddr=0x3100.
- Exception (ExcPc=0x3020) and Jump (0x5000) in the same cycle in IDLE -> PC=0x4180 and Epc=0x3020. A later Eret -> FetchAddr=0x3020.
- Stall=1 asserted during an outstanding fetch -> the ack is still consumed, FetchReq drops, and PC is held. After Stall=0, fetch resumes at PC+4.
- PC forced via JumpReg to 0xFFFF_FFFC, then ack -> next FetchAddr=0x0000_0000. Reset pulsed low mid-fetch -> FetchReq=0 asynchronously and PC=0x3000.
